// File: rtl/demux1to4_n.sv
// Registered 1-to-m demultiplexer: one valid/ready producer stream is steered into m one-word
// output slots, each drained by its own consumer. Optional round-robin steering: DEMUX_RR_EN.

module demux1to4_n_slot #(
  parameter int n = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [n-1:0] i_data,
  output logic         o_valid,
  output logic [n-1:0] o_data
);
  logic         r_valid;
  logic [n-1:0] r_data;

  // A load beats a drain, so a slot that empties and refills on one edge never bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

module demux1to4_n #(
  parameter int n       = 4,
  parameter int address = 2,
  parameter int m       = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       data_i,
  input  logic               valid_i,
  input  logic [address-1:0] sel,
  output logic               ready_o,
  output logic [n-1:0]       data_o [0:m-1],
  output logic [m-1:0]       valid_o,
  input  logic [m-1:0]       ready_i,
  output logic               sel_err_o
);
  localparam logic [address:0] M_L = (address+1)'(m);

  logic [address-1:0] w_tgt;
  logic               w_tgt_ok;
  logic [m-1:0]       w_onehot;
  logic [m-1:0]       w_drain;
  logic               w_acc;

`ifdef DEMUX_RR_EN
  logic [address-1:0] r_ptr;
  logic               w_sel_unused;

  assign w_tgt        = r_ptr;
  assign w_sel_unused = ^sel;

  // Rotation only advances on accept, so a stalled channel stalls the whole rotation.
  always_ff @(posedge clk_i) begin
    if (rst_i)      r_ptr <= '0;
    else if (w_acc) r_ptr <= (r_ptr == address'(m-1)) ? '0 : r_ptr + address'(1);
  end

  assign sel_err_o = 1'b0;
`else
  logic r_sel_err;

  assign w_tgt = sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_sel_err <= 1'b0;
    else       r_sel_err <= w_acc && !w_tgt_ok;
  end

  assign sel_err_o = r_sel_err;
`endif

  assign w_tgt_ok = ({1'b0, w_tgt} < M_L);
  assign w_drain  = valid_o & ready_i;
  // Out-of-range targets give an all-zero one-hot, so the word is sunk with ready_o high.
  assign ready_o  = ~|(w_onehot & valid_o & ~ready_i);
  assign w_acc    = valid_i && ready_o;

  for (genvar k = 0; k < m; k++) begin : g_slot
    assign w_onehot[k] = w_tgt_ok && (w_tgt == address'(k));

    demux1to4_n_slot #(.n(n)) u_slot (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_load  (w_acc && w_onehot[k]),
      .i_drain (w_drain[k]),
      .i_data  (data_i),
      .o_valid (valid_o[k]),
      .o_data  (data_o[k])
    );
  end
endmodule
